// File: rtl/mux_nx1_stream_pkg.sv
// Shared types and helpers for the N-to-1 streaming multiplexer.
package mux_stream_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int N     = 16,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_grant
);

  localparam int DW = 2 * N;

  logic [DW-1:0] req_dbl;
  logic [DW-1:0] req_masked;
  int            hit;

  always_comb begin
    // The upper copy of req supplies the wrapped-around requesters.
    req_dbl    = {req, req};
    req_masked = req_dbl & ~((DW'(1) << ptr) - DW'(1));
    hit        = 0;
    any_grant  = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (req_masked[i]) begin
        hit       = i;
        any_grant = 1'b1;
      end
    end
    grant_idx    = SEL_W'((hit >= N) ? hit - N : hit);
    grant_onehot = '0;
    if (any_grant) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-to-1 streaming mux with fixed-select or round-robin grant and a registered,
// backpressured output stage.
module mux_nx1_stream
  import mux_stream_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 1,
  parameter int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NP = 1 << SEL_W;

  mux_mode_e        mode_e;
  logic             load_en;
  logic             xfer;
  logic             any_grant;
  logic             arb_any;
  logic [N-1:0]     grant_oh;
  logic [N-1:0]     arb_oh;
  logic [N-1:0]     fix_oh;
  logic [NP-1:0]    sel_dec;
  logic [SEL_W-1:0] g_idx;
  logic [SEL_W-1:0] arb_idx;

  logic [W-1:0]     out_data_d,  out_data_q;
  logic [SEL_W-1:0] out_ch_d,    out_ch_q;
  logic             out_valid_d, out_valid_q;
  logic [SEL_W-1:0] rr_ptr_d,    rr_ptr_q;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req          (in_valid),
    .ptr          (rr_ptr_q),
    .grant_onehot (arb_oh),
    .grant_idx    (arb_idx),
    .any_grant    (arb_any)
  );

  always_comb begin
    mode_e  = mux_mode_e'(mode);
    load_en = !out_valid_q || out_ready;
    // Indices at or above N decode outside fix_oh, leaving no grant.
    sel_dec = NP'(1) << sel;
    fix_oh  = sel_dec[N-1:0];
    if (mode_e == MODE_RR) begin
      grant_oh  = arb_oh;
      g_idx     = arb_idx;
      any_grant = arb_any;
    end else begin
      grant_oh  = fix_oh;
      g_idx     = sel;
      any_grant = |fix_oh;
    end
    in_ready = (load_en && any_grant) ? grant_oh : '0;
    xfer     = |(in_valid & in_ready);

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = in_data[g_idx*W +: W];
        out_ch_d   = g_idx;
      end
    end
    if (xfer && mode_e == MODE_RR) begin
      rr_ptr_d = (g_idx == SEL_W'(N - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: directed scenarios plus random traffic against a
// behavioural model of the grant, handshake and output register.
module tb_mux_nx1_stream;

  localparam int N  = 16;
  localparam int W  = 1;
  localparam int SW = 4;
  localparam int NB = 12;
  localparam int WB = 4;
  localparam int SB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid, in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_ch;
  logic          out_valid, out_ready;

  logic           mode_b;
  logic [SB-1:0]  sel_b;
  logic [NB*WB-1:0] in_data_b;
  logic [NB-1:0]  in_valid_b, in_ready_b;
  logic [WB-1:0]  out_data_b;
  logic [SB-1:0]  out_ch_b;
  logic           out_valid_b, out_ready_b;

  mux_nx1_stream #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nx1_stream #(.N(NB), .W(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel_b), .in_data(in_data_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_ch(out_ch_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  int checks = 0;
  int passes = 0;

  // Model of the main instance: output register contents and round-robin pointer.
  int m_valid, m_data, m_ch, m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    int g, sv;
    bit has, le, xfer;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    has = 0;
    g   = 0;
    sv  = sel;
    if (mode == 1'b0) begin
      if (sv < N) begin has = 1; g = sv; end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!has && in_valid[(m_ptr + k) % N]) begin
          has = 1;
          g   = (m_ptr + k) % N;
        end
      end
    end
    le      = (m_valid == 0) || out_ready;
    exp_rdy = '0;
    if (has && le) exp_rdy[g] = 1'b1;
    chk("out_valid", 32'(out_valid), m_valid);
    chk("out_data",  32'(out_data),  m_data);
    chk("out_ch",    32'(out_ch),    m_ch);
    chk("in_ready",  32'(in_ready),  32'(exp_rdy));
    chk("rr_ptr",    32'(dut.rr_ptr_q), m_ptr);
    xfer = has && le && in_valid[g];
    if (le) begin
      m_valid = xfer;
      if (xfer) begin
        m_data = in_data[g];
        m_ch   = g;
        if (mode) m_ptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
  endtask

  int s1[4] = '{5, 12, 8, 3};
  int d1[4] = '{0, 0, 1, 1};
  int s2[4] = '{0, 5, 10, 15};
  int d2[4] = '{1, 0, 0, 1};
  int rr[6] = '{0, 4, 8, 0, 4, 8};

  initial begin
    mode = 0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1;
    mode_b = 0; sel_b = 4'd13; in_data_b = '0; in_valid_b = '1; out_ready_b = 1;
    model_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_ch",    32'(out_ch),    0);
    chk("rst_rr_ptr",    32'(dut.rr_ptr_q), 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Fixed-select sweep
    in_valid = '1; in_data = 16'h674F;
    for (int i = 0; i < 4; i++) begin
      sel = SW'(s1[i]);
      tick();
      chk("t1a_data", 32'(out_data), d1[i]);
      chk("t1a_ch",   32'(out_ch),   s1[i]);
    end
    in_data = 16'hA017;
    for (int i = 0; i < 4; i++) begin
      sel = SW'(s2[i]);
      tick();
      chk("t1b_data", 32'(out_data), d2[i]);
    end

    // Round-robin fairness over channels 0, 4, 8
    mode = 1; in_valid = 16'h0111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_ch",    32'(out_ch),    rr[i]);
      chk("t2_valid", 32'(out_valid), 1);
    end

    // Backpressure: hold three cycles, then resume with no bubble
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_ch", 32'(out_ch),   8);
      chk("t3_ready0",  32'(in_ready), 0);
    end
    out_ready = 1;
    tick();
    chk("t3_resume_ch", 32'(out_ch), 0);
    tick();
    chk("t3_next_ch",   32'(out_ch), 4);

    // Idle channel under fixed select
    mode = 0; sel = 4'd7; in_valid = 16'hFF7F;
    tick();
    chk("t4_idle_valid", 32'(out_valid), 0);
    tick();
    chk("t4_idle_hold",  32'(out_valid), 0);

    // Out-of-range select on the 12-channel instance
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_b_ready", 32'(in_ready_b),  0);
      chk("t4_b_valid", 32'(out_valid_b), 0);
    end
    in_data_b = 48'hA5C3_9E71_B2D4;
    sel_b = 4'd11;
    @(posedge clk); #1;
    chk("t4_b_ch",   32'(out_ch_b),    11);
    chk("t4_b_data", 32'(out_data_b),  32'hA);
    chk("t4_b_vld",  32'(out_valid_b), 1);
    sel_b = 4'd13;

    // Wrap 15 -> 0 then mode switch keeps the pointer
    mode = 1; in_valid = 16'h4000;
    tick();
    chk("t5_ch14", 32'(out_ch), 14);
    in_valid = 16'h8004;
    tick();
    chk("t5_ch15", 32'(out_ch), 15);
    tick();
    chk("t5_ch2",  32'(out_ch), 2);
    mode = 0; sel = 4'd9; in_valid = '1;
    tick();
    chk("t5_ch9",  32'(out_ch), 9);
    chk("t5_ptr",  32'(dut.rr_ptr_q), 3);

    // Asynchronous reset between edges
    mode = 1; in_valid = 16'h0111;
    tick();
    tick();
    in_valid = 16'h8421;
    #3;
    rst_n = 0;
    #1;
    model_reset();
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_data",  32'(out_data),  0);
    chk("t6_ch",    32'(out_ch),    0);
    chk("t6_ptr",   32'(dut.rr_ptr_q), 0);
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    chk("t6_first_rr", 32'(out_ch), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom);
      in_valid  = N'($urandom & $urandom);
      in_data   = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
Parametrised N-to-1 streaming multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two modes:
  - Fixed-select: the channel is chosen by sel.
  - Round-robin: the block scans valid channels fairly.
- Generalises the team's combinational 16x1 mux for shared-bus and datapath-merge use. Adds pipelining, backpressure and fair arbitration.

Parameters:
- N, 16, number of input channels (2..64).
- W, 1, data width per channel in bits.
- SEL_W, $clog2(N), width of the channel index. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed-select mode.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready. Combinational; at most one bit high per cycle.
- out_data  output  W  registered output data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (asynchronous assert, synchronous release): out_data=0, out_ch=0, out_valid=0, rr_ptr=0.
- load_en = !out_valid || out_ready. The output register accepts a new word only when it is empty or draining this cycle.
- Grant logic (combinational, one-hot grant):
  - Fixed mode: grant = sel if sel < N. If sel >= N there is no grant and no in_ready is asserted.
  - Round-robin mode: grant = first i with in_valid[i]=1, searching from rr_ptr upward and wrapping N-1 -> 0. If no channel is valid there is no grant.
- in_ready[g] = load_en for the granted channel g. All other in_ready bits are 0. In fixed mode, in_ready[sel] may be high while in_valid[sel]=0; in that case no transfer occurs.
- Input transfer occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= in_data[g];
  - out_ch <= g;
  - out_valid <= 1.
- If load_en=1 and no transfer occurs, out_valid <= 0 on the next edge. out_data and out_ch hold their last values.
- If out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold unchanged. All in_ready bits are 0.
- Latency: one cycle from input transfer to out_valid. Sustained throughput is one word per cycle when out_ready=1.
- rr_ptr:
  - Updates only on a transfer in round-robin mode: rr_ptr <= (g == N-1) ? 0 : g+1.
  - Holds in fixed mode.
  - Is retained across mode changes.
- Mode and sel are sampled each cycle combinationally. A change takes effect in the same cycle's grant. A word already in the output register is unaffected.
- Simultaneous output drain and new input transfer: both happen in the same cycle, with no bubble.
- Reset asserted mid-transfer: the output is cleared immediately and the pending word is discarded.

Decomposition:
- Package mux_stream_pkg:
  - localparam helper function for SEL_W;
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_e.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr[SEL_W]; outputs grant_onehot[N], grant_idx[SEL_W] and any_grant.
  - Implemented as double-width priority search with wrap.
  - The top level holds rr_ptr, the fixed/RR grant select, the handshake logic and the output register.

Test Plan:
1. Fixed-select sweep. N=16, W=1, in_data=16'h674F, all in_valid=1, out_ready=1, mode=0. Apply sel=5, 12, 8, 3 on consecutive cycles -> one cycle later out_data=0, 0, 1, 1 and out_ch=5, 12, 8, 3. Then in_data=16'hA017 with sel=0, 5, 10, 15 -> out_data=1, 0, 0, 1.
2. Round-robin fairness. mode=1, in_valid=16'h0111 held, out_ready=1 -> out_ch sequence 0, 4, 8, 0, 4, 8 with no bubbles. in_ready toggles one-hot across channels 0, 4, 8.
3. Backpressure. Hold out_ready=0 while out_valid=1 for 3 cycles -> out_data and out_ch stable and all in_ready=0. Release -> the next word follows in the same cycle, with no loss and no duplication.
4. Idle and invalid select. mode=0, sel=7, in_valid[7]=0 -> out_valid falls to 0 after the drain. N=12 with sel=13 -> in_ready=0 and out_valid stays 0.
5. Wrap and mode switch. mode=1 with rr_ptr=15 after granting channel 14; in_valid={ch15, ch2} -> grants 15 then 2. Switch to mode=0, sel=9 -> the next word is from ch9 and rr_ptr holds at 3.
6. Async reset. Assert rst_n=0 mid-stream between clock edges -> out_valid, out_data, out_ch and rr_ptr go to 0 immediately. After release, the first RR grant searches from channel 0.
